// File: rtl/mem_bus_if_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if_if : system-bus signal bundle between a memory-stage bus master
// and the bus/slave side.
//
// Parameters
//   ADDR_W  word-address width
//   DATA_W  data width
//
// Signals (active-low names end in '_')
//   bus_req_    master -> slave  bus request
//   bus_grnt_   slave  -> master bus grant
//   bus_as_     master -> slave  address strobe, one cycle per access
//   bus_rw      master -> slave  1=read, 0=write
//   bus_addr    master -> slave  word address
//   bus_wr_data master -> slave  write data
//   bus_rd_data slave  -> master read data, valid while bus_rdy_=0
//   bus_rdy_    slave  -> master access complete
//   bus_err     master -> slave  timeout pulse
// ---------------------------------------------------------------------------
interface mem_bus_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              bus_req_;
  logic              bus_grnt_;
  logic              bus_as_;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;
  logic              bus_err;

  modport master (
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );
endinterface

// File: rtl/mem_bus_if.sv
// ---------------------------------------------------------------------------
// mem_bus_if : memory-stage bus master.
//
// Converts a MEM-stage load/store into a request/grant/strobe/ready bus
// transaction, returns the load word and the alignment fault to MEM/WB and
// raises busy to stall the pipeline until the access completes.
//
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort an access that sits
// in REQ/ACCESS for TIMEOUT_CYC cycles (bus_err pulses for one cycle).
// Without it the master waits indefinitely and bus_err is tied 0.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   stall             pipeline stall; the request is held while high
//   flush             pipeline flush
//   req_en, req_rw    valid load/store, 1=read 0=write
//   byte_addr         byte address from EX
//   wr_data           store data
//   out               load result (0 for writes, faults and idle)
//   miss_align        byte_addr[1:0]!=0 on a requested access
//   busy              stall request to pipeline control
//   bus               system bus (mem_bus_if_if.master)
// ---------------------------------------------------------------------------
module mem_bus_if #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        req_en,
  input  logic        req_rw,
  input  logic [31:0] byte_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] out,
  output logic        miss_align,
  output logic        busy,
  mem_bus_if_if.master bus
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACCESS,
    S_STALL
  } state_t;

  state_t            r_state;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic              r_bus_rw;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wr_data;
  logic [DATA_W-1:0] r_rd_buf;

  logic w_start;
  logic w_grant;
  logic w_rdy;
  logic w_timeout;
  logic w_abort;

  assign w_start = req_en & ~flush & (byte_addr[1:0] == 2'b00);
  assign w_grant = ~bus.bus_grnt_;
  assign w_rdy   = ~bus.bus_rdy_;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_bus_err;

  // Held at zero outside REQ/ACCESS, so every entry into REQ starts from 0.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE || r_state == S_STALL) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_timeout = ((r_state == S_REQ) || (r_state == S_ACCESS)) &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign bus.bus_err = r_bus_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  // A ready arriving in the same cycle as the timeout completes normally.
  assign w_abort = w_timeout & ~((r_state == S_ACCESS) & w_rdy);

  assign bus.bus_req_    = r_bus_req_;
  assign bus.bus_as_     = r_bus_as_;
  assign bus.bus_rw      = r_bus_rw;
  assign bus.bus_addr    = r_bus_addr;
  assign bus.bus_wr_data = r_bus_wr_data;

  // Pipeline-facing outputs: combinational so the request cycle and the
  // ready cycle are visible to the pipeline without an extra stall cycle.
  always_comb begin
    miss_align = req_en & (byte_addr[1:0] != 2'b00);
    busy       = 1'b0;
    out        = '0;
    case (r_state)
      S_IDLE:   busy = w_start;
      S_REQ:    busy = ~w_abort;
      S_ACCESS: begin
        if (w_rdy) begin
          busy = 1'b0;
          out  = r_bus_rw ? 32'(bus.bus_rd_data) : 32'd0;
        end else begin
          busy = ~w_abort;
        end
      end
      S_STALL:  out = r_bus_rw ? 32'(r_rd_buf) : 32'd0;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bus_req_    <= 1'b1;
      r_bus_as_     <= 1'b1;
      r_bus_rw      <= 1'b1;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_rd_buf      <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      r_bus_err     <= 1'b0;
`endif
    end else begin
`ifdef MEM_BUS_TIMEOUT_EN
      r_bus_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bus_req_    <= 1'b0;
            r_bus_addr    <= byte_addr[ADDR_W+1:2];
            r_bus_rw      <= req_rw;
            r_bus_wr_data <= DATA_W'(wr_data);
            r_state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            r_bus_req_ <= 1'b1;
            r_state    <= S_IDLE;
          end else if (w_abort) begin
            r_bus_req_ <= 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
            r_bus_err  <= 1'b1;
`endif
            r_state    <= stall ? S_STALL : S_IDLE;
          end else if (w_grant) begin
            r_bus_as_  <= 1'b0;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // Strobe is a single-cycle pulse; flush is deliberately ignored so
          // the slave never sees a transaction abandoned mid-flight.
          r_bus_as_ <= 1'b1;
          if (w_rdy) begin
            r_rd_buf   <= bus.bus_rd_data;
            r_bus_req_ <= 1'b1;
            r_state    <= stall ? S_STALL : S_IDLE;
          end else if (w_abort) begin
            r_bus_req_ <= 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
            r_bus_err  <= 1'b1;
`endif
            r_state    <= stall ? S_STALL : S_IDLE;
          end
        end
        S_STALL: begin
          if (!stall) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
module tb_mem_bus_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        req_en;
  logic        req_rw;
  logic [31:0] byte_addr;
  logic [31:0] wr_data;
  logic [31:0] out;
  logic        miss_align;
  logic        busy;

  mem_bus_if_if #(.ADDR_W(30), .DATA_W(32)) bus_i ();

  mem_bus_if #(.ADDR_W(30), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .req_en(req_en), .req_rw(req_rw), .byte_addr(byte_addr), .wr_data(wr_data),
    .out(out), .miss_align(miss_align), .busy(busy), .bus(bus_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  // Bus activity monitor: strobe-low cycles and request falling edges.
  int   as_cnt   = 0;
  int   req_fall = 0;
  logic prev_req = 1'b1;
  always @(negedge clk) begin
    if (bus_i.bus_as_ === 1'b0) as_cnt++;
    if (prev_req === 1'b1 && bus_i.bus_req_ === 1'b0) req_fall++;
    prev_req = bus_i.bus_req_;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; req_en = 0; req_rw = 1; byte_addr = 0; wr_data = 0;
    bus_i.bus_grnt_ = 1; bus_i.bus_rdy_ = 1; bus_i.bus_rd_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    n_vec++; if (bus_i.bus_req_ !== 1'b1) begin n_err++; $display("FAIL rst_req: got %b want 1", bus_i.bus_req_); end
    n_vec++; if (bus_i.bus_as_ !== 1'b1) begin n_err++; $display("FAIL rst_as: got %b want 1", bus_i.bus_as_); end
    n_vec++; if (bus_i.bus_rw !== 1'b1) begin n_err++; $display("FAIL rst_rw: got %b want 1", bus_i.bus_rw); end
    n_vec++; if (bus_i.bus_addr !== 30'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus_i.bus_addr); end
    n_vec++; if (bus_i.bus_wr_data !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", bus_i.bus_wr_data); end
    n_vec++; if (bus_i.bus_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus_i.bus_err); end
    n_vec++; if ({out, busy, miss_align} !== 34'd0) begin n_err++; $display("FAIL rst_pipe: got out=%h busy=%b ma=%b want 0", out, busy, miss_align); end
    reset = 0;
    step();
  endtask

  task automatic test_read();
    int a0;
    logic [31:0] exp;
    a0 = as_cnt;
    req_en = 1; req_rw = 1; byte_addr = 32'h100;
    sb_q.push_back(32'hDEADBEEF);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_req: got %b want 1", busy); end
    step();
    n_vec++; if (bus_i.bus_req_ !== 1'b0) begin n_err++; $display("FAIL rd_req_low: got %b want 0", bus_i.bus_req_); end
    n_vec++; if (bus_i.bus_addr !== 30'h40 || bus_i.bus_rw !== 1'b1) begin n_err++; $display("FAIL rd_addr: got %h/%b want 40/1", bus_i.bus_addr, bus_i.bus_rw); end
    step();
    bus_i.bus_grnt_ = 0;
    step();
    bus_i.bus_grnt_ = 1;
    n_vec++; if (bus_i.bus_as_ !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rd_as: got as=%b busy=%b want 0/1", bus_i.bus_as_, busy); end
    step();
    bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'hDEADBEEF;
    #1;
    exp = sb_q.pop_front();
    n_vec++; if (out !== exp || busy !== 1'b0) begin n_err++; $display("FAIL rd_data: got %h busy=%b want %h busy=0", out, busy, exp); end
    n_vec++; if (bus_i.bus_req_ !== 1'b0) begin n_err++; $display("FAIL rd_req_rdy: got %b want 0", bus_i.bus_req_); end
    step();
    req_en = 0; bus_i.bus_rdy_ = 1;
    #1;
    n_vec++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0 || out !== 32'd0) begin n_err++; $display("FAIL rd_done: got req=%b busy=%b out=%h want 1/0/0", bus_i.bus_req_, busy, out); end
    n_vec++; if (as_cnt - a0 !== 1) begin n_err++; $display("FAIL rd_as_pulses: got %0d want 1", as_cnt - a0); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3];
    addrs[0] = 32'h102; addrs[1] = 32'h101; addrs[2] = 32'h203;
    for (int i = 0; i < 3; i++) begin
      req_en = 1; req_rw = 1; byte_addr = addrs[i];
      #1;
      n_vec++; if (miss_align !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL ma_%0d: got ma=%b busy=%b want 1/0", i, miss_align, busy); end
      step();
      n_vec++; if (bus_i.bus_req_ !== 1'b1 || out !== 32'd0) begin n_err++; $display("FAIL ma_bus_%0d: got req=%b out=%h want 1/0", i, bus_i.bus_req_, out); end
    end
    req_en = 0;
    #1;
    n_vec++; if (miss_align !== 1'b0) begin n_err++; $display("FAIL ma_noreq: got %b want 0", miss_align); end
  endtask

  task automatic test_write_stall();
    int a0, r0;
    logic [31:0] exp;
    a0 = as_cnt; r0 = req_fall;
    req_en = 1; req_rw = 0; byte_addr = 32'h200; wr_data = 32'h55AA55AA;
    bus_i.bus_grnt_ = 0;
    sb_q.push_back(32'd0);
    step();
    n_vec++; if (bus_i.bus_rw !== 1'b0 || bus_i.bus_wr_data !== 32'h55AA55AA || bus_i.bus_addr !== 30'h80) begin n_err++; $display("FAIL wr_bus: got rw=%b wd=%h a=%h want 0/55aa55aa/80", bus_i.bus_rw, bus_i.bus_wr_data, bus_i.bus_addr); end
    step();
    bus_i.bus_grnt_ = 1; bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'h11111111; stall = 1;
    #1;
    exp = sb_q.pop_front();
    n_vec++; if (out !== exp || busy !== 1'b0) begin n_err++; $display("FAIL wr_rdy: got out=%h busy=%b want %h/0", out, busy, exp); end
    for (int i = 0; i < 3; i++) begin
      step();
      bus_i.bus_rdy_ = 1;
      #1;
      n_vec++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0 || out !== 32'd0) begin n_err++; $display("FAIL wr_stall_%0d: got req=%b busy=%b out=%h want 1/0/0", i, bus_i.bus_req_, busy, out); end
    end
    stall = 0;
    step();
    req_en = 0;
    #1;
    n_vec++; if (as_cnt - a0 !== 1 || req_fall - r0 !== 1) begin n_err++; $display("FAIL wr_reissue: got as=%0d req=%0d want 1/1", as_cnt - a0, req_fall - r0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [2];
    logic [31:0] exp;
    int nbusy;
    bit done;
    data[0] = 32'h12345678; data[1] = 32'hA5A5F00D;
    bus_i.bus_grnt_ = 0; bus_i.bus_rdy_ = 0;
    for (int k = 0; k < 2; k++) begin
      req_en = 1; req_rw = 1; byte_addr = 32'h300 + 32'(k * 4);
      bus_i.bus_rd_data = data[k];
      stall = (k == 0);
      sb_q.push_back(data[k]);
      nbusy = 0; done = 0;
      #1;
      for (int c = 0; c < 10 && !done; c++) begin
        if (!busy) done = 1;
        else begin nbusy++; step(); end
      end
      exp = sb_q.pop_front();
      n_vec++; if (!done || nbusy != 2) begin n_err++; $display("FAIL b2b_lat_%0d: got done=%0d busy_cycles=%0d want 1/2", k, done, nbusy); end
      n_vec++; if (out !== exp) begin n_err++; $display("FAIL b2b_out_%0d: got %h want %h", k, out, exp); end
      if (k == 0) begin
        step();
        bus_i.bus_rd_data = 32'h0;
        n_vec++; if (out !== exp || busy !== 1'b0) begin n_err++; $display("FAIL b2b_rdbuf: got %h busy=%b want %h/0", out, busy, exp); end
        stall = 0;
      end
      step();
    end
    req_en = 0; bus_i.bus_grnt_ = 1; bus_i.bus_rdy_ = 1; stall = 0;
    step();
  endtask

  task automatic test_flush_req();
    int a0;
    req_en = 1; req_rw = 1; byte_addr = 32'h400;
    a0 = as_cnt;
    step();
    step();
    flush = 1;
    #1;
    n_vec++; if (bus_i.bus_req_ !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fl_req_pre: got req=%b busy=%b want 0/1", bus_i.bus_req_, busy); end
    step();
    flush = 0; req_en = 0;
    #1;
    n_vec++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0 || as_cnt != a0) begin n_err++; $display("FAIL fl_req: got req=%b busy=%b as=%0d want 1/0/0", bus_i.bus_req_, busy, as_cnt - a0); end
  endtask

  task automatic test_flush_access();
    logic [31:0] exp;
    req_en = 1; req_rw = 1; byte_addr = 32'h500; bus_i.bus_grnt_ = 0;
    sb_q.push_back(32'hCAFEF00D);
    step();
    step();
    bus_i.bus_grnt_ = 1; flush = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (bus_i.bus_req_ !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fl_acc_%0d: got req=%b busy=%b want 0/1", i, bus_i.bus_req_, busy); end
    end
    bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'hCAFEF00D;
    #1;
    exp = sb_q.pop_front();
    n_vec++; if (out !== exp || busy !== 1'b0) begin n_err++; $display("FAIL fl_acc_rdy: got %h busy=%b want %h/0", out, busy, exp); end
    step();
    flush = 0; req_en = 0; bus_i.bus_rdy_ = 1;
    #1;
    n_vec++; if (bus_i.bus_req_ !== 1'b1) begin n_err++; $display("FAIL fl_acc_done: got %b want 1", bus_i.bus_req_); end
  endtask

  task automatic test_reset_access();
    req_en = 1; req_rw = 1; byte_addr = 32'h600; bus_i.bus_grnt_ = 0;
    step();
    step();
    bus_i.bus_grnt_ = 1;
    step();
    reset = 1; req_en = 0;
    step();
    reset = 0;
    bus_i.bus_rdy_ = 0; bus_i.bus_rd_data = 32'h77777777;
    #1;
    n_vec++; if (bus_i.bus_req_ !== 1'b1 || bus_i.bus_as_ !== 1'b1 || bus_i.bus_addr !== 30'd0) begin n_err++; $display("FAIL rst_acc_bus: got req=%b as=%b a=%h want 1/1/0", bus_i.bus_req_, bus_i.bus_as_, bus_i.bus_addr); end
    n_vec++; if (out !== 32'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_acc_pipe: got out=%h busy=%b want 0/0", out, busy); end
    step();
    bus_i.bus_rdy_ = 1;
  endtask

  task automatic test_timeout();
    int err_at;
    int err_cnt;
    req_en = 1; req_rw = 1; byte_addr = 32'h700; bus_i.bus_grnt_ = 1;
    err_at = 0; err_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus_i.bus_err === 1'b1) begin
        err_cnt++;
        if (err_at == 0) err_at = k;
        req_en = 0;
      end
    end
`ifdef MEM_BUS_TIMEOUT_EN
    n_vec++; if (err_at != 9 || err_cnt != 1) begin n_err++; $display("FAIL tmo_err: got edge=%0d pulses=%0d want 9/1", err_at, err_cnt); end
    n_vec++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL tmo_release: got req=%b busy=%b want 1/0", bus_i.bus_req_, busy); end
`else
    n_vec++; if (err_cnt != 0) begin n_err++; $display("FAIL tmo_err: got pulses=%0d want 0", err_cnt); end
    n_vec++; if (bus_i.bus_req_ !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL tmo_wait: got req=%b busy=%b want 0/1", bus_i.bus_req_, busy); end
    flush = 1;
    step();
    flush = 0; req_en = 0;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_misalign();
    test_write_stall();
    test_back_to_back();
    test_flush_req();
    test_flush_access();
    test_reset_access();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
